// File: rtl/rvv_backend_trap_ctrl.sv
// Trap sequencer between RVS and the RVV command queue. It stops the queue, flushes the
// command and uops queues, waits for older uops to retire, then acknowledges the trap.
module rvv_backend_trap_ctrl #(
   parameter int ROB_DEPTH     = 8,
   parameter int ROB_IDX_W     = $clog2(ROB_DEPTH),
   parameter int DRAIN_TIMEOUT = 1024,
   parameter int CNT_W         = 11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 trap_valid_rvs2rvv,
   input  logic [ROB_IDX_W-1:0] trap_rob_entry_rvs2rvv,
   output logic                 trap_ready_rvv2rvs,
   input  logic                 rob_empty,
   input  logic [ROB_IDX_W-1:0] rob_head_entry,
   output logic                 stop_cmdq_wb2if,
   output logic                 flush_cmdq_wb2if,
   output logic                 flush_uopq,
   output logic                 trap_busy,
   output logic                 trap_timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_STOP  = 3'd1,
      S_FLUSH = 3'd2,
      S_DRAIN = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(DRAIN_TIMEOUT);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ROB_IDX_W-1:0] r_entry;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_inc;
   logic                 w_drain_done;

   logic r_stop;
   logic r_flush;
   logic r_ready;
   logic r_busy;
   logic r_err;
   logic w_stop_nxt;
   logic w_flush_nxt;
   logic w_ready_nxt;
   logic w_busy_nxt;

   // The trapping entry itself is not waited on: head reaching it means all older uops retired.
   assign w_drain_done = rob_empty || (rob_head_entry == r_entry);
   assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

   // State register; outputs are flopped from the decode of the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_stop  <= 1'b0;
         r_flush <= 1'b0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_stop  <= w_stop_nxt;
         r_flush <= w_flush_nxt;
         r_ready <= w_ready_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (trap_valid_rvs2rvv) w_state_nxt = S_STOP;
         S_STOP:  w_state_nxt = S_FLUSH;
         S_FLUSH: w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_drain_done) w_state_nxt = S_RESP;
         // Ready is high throughout RESP, so valid alone completes the handshake.
         S_RESP:  if (trap_valid_rvs2rvv) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_stop_nxt  = (w_state_nxt != S_IDLE);
      w_flush_nxt = (w_state_nxt == S_FLUSH);
      w_ready_nxt = (w_state_nxt == S_RESP);
      w_busy_nxt  = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_entry <= '0;
      end else if ((r_state == S_IDLE) && trap_valid_rvs2rvv) begin
         r_entry <= trap_rob_entry_rvs2rvv;
      end
   end

   // Counter value equals the number of completed DRAIN cycles of the current trap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_state == S_FLUSH) begin
         r_cnt <= '0;
      end else if (r_state == S_DRAIN) begin
         r_cnt <= w_cnt_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if ((r_state == S_DRAIN) && (w_cnt_inc == TIMEOUT_C)) begin
         r_err <= 1'b1;
      end
   end

   assign stop_cmdq_wb2if    = r_stop;
   assign flush_cmdq_wb2if   = r_flush;
   assign flush_uopq         = r_flush;
   assign trap_ready_rvv2rvs = r_ready;
   assign trap_busy          = r_busy;
   assign trap_timeout_err   = r_err;

endmodule

// File: tb/tb_rvv_backend_trap_ctrl.sv
// Directed bench for rvv_backend_trap_ctrl: a vector table for the basic and back-to-back
// flows, plus hand-written drain, wrap-around, timeout and mid-sequence reset sequences.
module tb_rvv_backend_trap_ctrl;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid = 1'b0;
   logic [2:0] entry = 3'd0;
   logic       empty = 1'b0;
   logic [2:0] head  = 3'd0;
   logic       ready;
   logic       stop;
   logic       flc;
   logic       flu;
   logic       busy;
   logic       err;

   int n_chk  = 0;
   int n_fail = 0;

   // Output vector order: {stop, flush_cmdq, flush_uopq, ready, busy, timeout_err}
   localparam logic [5:0] IDLE_O  = 6'b000000;
   localparam logic [5:0] STOP_O  = 6'b100010;
   localparam logic [5:0] FLUSH_O = 6'b111010;
   localparam logic [5:0] DRAIN_O = 6'b100010;
   localparam logic [5:0] RESP_O  = 6'b100110;
   localparam logic [5:0] ERR_O   = 6'b000001;

   typedef struct {
      logic       v;
      logic [2:0] e;
      logic       em;
      logic [2:0] h;
      logic [5:0] exp;
      string      name;
   } vec_t;

   vec_t tbl [12];

   rvv_backend_trap_ctrl #(
      .ROB_DEPTH    (8),
      .ROB_IDX_W    (3),
      .DRAIN_TIMEOUT(16),
      .CNT_W        (11)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .trap_valid_rvs2rvv    (valid),
      .trap_rob_entry_rvs2rvv(entry),
      .trap_ready_rvv2rvs    (ready),
      .rob_empty             (empty),
      .rob_head_entry        (head),
      .stop_cmdq_wb2if       (stop),
      .flush_cmdq_wb2if      (flc),
      .flush_uopq            (flu),
      .trap_busy             (busy),
      .trap_timeout_err      (err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic v, input logic [2:0] e, input logic em,
                               input logic [2:0] h, input logic [5:0] exp, input string name);
      vec_t r;
      r.v = v; r.e = e; r.em = em; r.h = h; r.exp = exp; r.name = name;
      return r;
   endfunction

   task automatic check(input string nm, input logic [5:0] exp);
      logic [5:0] act;
      act = {stop, flc, flu, ready, busy, err};
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (stop,flc,flu,rdy,busy,err)", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] e, input logic em, input logic [2:0] h);
      valid = v;
      entry = e;
      empty = em;
      head  = h;
   endtask

   task automatic step(input string nm, input logic [5:0] exp);
      @(posedge clk);
      #1;
      check(nm, exp);
   endtask

   initial begin
      // Basic trap (cycles 0..5), then back-to-back with a held valid, then a valid drop in RESP.
      tbl[0]  = mk(1'b1, 3'd5, 1'b1, 3'd0, STOP_O,  "basic_stop");
      tbl[1]  = mk(1'b1, 3'd5, 1'b1, 3'd0, FLUSH_O, "basic_flush");
      tbl[2]  = mk(1'b1, 3'd5, 1'b1, 3'd0, DRAIN_O, "basic_drain");
      tbl[3]  = mk(1'b1, 3'd5, 1'b1, 3'd0, RESP_O,  "basic_resp");
      tbl[4]  = mk(1'b1, 3'd5, 1'b1, 3'd0, IDLE_O,  "basic_handshake_idle");
      tbl[5]  = mk(1'b1, 3'd1, 1'b1, 3'd0, STOP_O,  "b2b_stop");
      tbl[6]  = mk(1'b1, 3'd1, 1'b1, 3'd0, FLUSH_O, "b2b_flush");
      tbl[7]  = mk(1'b1, 3'd1, 1'b1, 3'd0, DRAIN_O, "b2b_flush_ends");
      tbl[8]  = mk(1'b1, 3'd1, 1'b1, 3'd0, RESP_O,  "b2b_resp");
      tbl[9]  = mk(1'b0, 3'd1, 1'b1, 3'd0, RESP_O,  "resp_valid_drop_hold");
      tbl[10] = mk(1'b1, 3'd1, 1'b1, 3'd0, IDLE_O,  "b2b_handshake_idle");
      tbl[11] = mk(1'b0, 3'd1, 1'b1, 3'd0, IDLE_O,  "idle_stay");

      drive(1'b1, 3'd5, 1'b1, 3'd0);
      #12;
      check("reset_state", IDLE_O);
      valid = 1'b0;
      #1;
      rst_n = 1'b1;
      step("post_reset_idle", IDLE_O);

      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].v, tbl[i].e, tbl[i].em, tbl[i].h);
         step(tbl[i].name, tbl[i].exp);
      end

      // Drain wait: head must reach entry 6 before ready appears.
      drive(1'b1, 3'd6, 1'b0, 3'd3);
      step("dw_stop", STOP_O);
      step("dw_flush", FLUSH_O);
      step("dw_drain_first", DRAIN_O);
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 3'd6, 1'b0, (k < 5) ? 3'd4 : 3'd5);
         step("dw_drain_wait", DRAIN_O);
      end
      drive(1'b1, 3'd6, 1'b0, 3'd6);
      step("dw_resp", RESP_O);
      step("dw_handshake_idle", IDLE_O);
      drive(1'b0, 3'd6, 1'b0, 3'd6);
      step("dw_idle", IDLE_O);

      // Wrap-around with the live entry input changed to 2 after it was latched as 0.
      drive(1'b1, 3'd0, 1'b0, 3'd6);
      step("wr_stop", STOP_O);
      drive(1'b1, 3'd2, 1'b0, 3'd6);
      step("wr_flush", FLUSH_O);
      step("wr_drain_h6", DRAIN_O);
      drive(1'b1, 3'd2, 1'b0, 3'd7);
      step("wr_drain_h7", DRAIN_O);
      drive(1'b1, 3'd2, 1'b0, 3'd2);
      step("wr_drain_h2_ignored", DRAIN_O);
      drive(1'b1, 3'd2, 1'b0, 3'd0);
      step("wr_resp_h0", RESP_O);
      step("wr_handshake_idle", IDLE_O);
      drive(1'b0, 3'd2, 1'b0, 3'd0);
      step("wr_idle", IDLE_O);

      // Timeout: err appears once 16 DRAIN cycles have completed; state stays DRAIN.
      drive(1'b1, 3'd4, 1'b0, 3'd1);
      step("to_stop", STOP_O);
      step("to_flush", FLUSH_O);
      step("to_drain_1", DRAIN_O);
      for (int k = 2; k <= 16; k++) begin
         step("to_drain_no_err", DRAIN_O);
      end
      step("to_err_set", DRAIN_O | ERR_O);
      step("to_still_drain", DRAIN_O | ERR_O);
      drive(1'b1, 3'd4, 1'b1, 3'd1);
      step("to_resp_on_empty", RESP_O | ERR_O);
      step("to_idle_err_sticky", IDLE_O | ERR_O);
      drive(1'b0, 3'd4, 1'b1, 3'd1);
      step("to_idle_hold", IDLE_O | ERR_O);

      // Asynchronous reset in the middle of DRAIN.
      drive(1'b1, 3'd3, 1'b0, 3'd5);
      step("rs_stop", STOP_O | ERR_O);
      step("rs_flush", FLUSH_O | ERR_O);
      step("rs_drain", DRAIN_O | ERR_O);
      #2;
      rst_n = 1'b0;
      #1;
      check("rs_async_clear", IDLE_O);
      #2;
      drive(1'b0, 3'd3, 1'b0, 3'd5);
      rst_n = 1'b1;
      step("rs_idle_after_release", IDLE_O);
      drive(1'b1, 3'd5, 1'b1, 3'd0);
      step("rs_restart_stop", STOP_O);
      step("rs_restart_flush", FLUSH_O);
      step("rs_restart_drain", DRAIN_O);
      step("rs_restart_resp", RESP_O);
      step("rs_restart_idle", IDLE_O);
      drive(1'b0, 3'd5, 1'b1, 3'd0);
      step("rs_final_idle", IDLE_O);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
